// File: rtl/seq_mult_bw.sv
// Sequential shift-add multiplier, one partial-product row per clock.
// Supports unsigned x unsigned (tc=0) and two's-complement x two's-complement
// (tc=1) using Baugh-Wooley row toggling plus a one-time correction constant.
// Latency: done pulses after the WIDTH-th rising edge following the accept edge.
module seq_mult_bw #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
    // Baugh-Wooley correction: 2^WIDTH + 2^(2*WIDTH-1)
    localparam logic [PW-1:0] Corr = PW'((64'd1 << (PW - 1)) | (64'd1 << WIDTH));

    // Reject unsupported operand widths at elaboration time.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("seq_mult_bw: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              tc_q, tc_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;

    logic              last_row;
    logic [WIDTH-1:0]  row_bits;
    logic [PW-1:0]     row_shift;
    logic [PW-1:0]     acc_sum;

    // Current partial-product row, with signed-mode toggles on the sign-involved bits.
    always_comb begin
        last_row = (cnt_q == LastCnt);
        row_bits = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            // Toggle when exactly one of a[WIDTH-1], b[WIDTH-1] takes part in this bit.
            row_bits[j] = (a_q[j] & b_q[cnt_q]) ^ (tc_q & ((j == int'(WIDTH) - 1) ^ last_row));
        end
        row_shift = PW'(row_bits) << cnt_q;
        // Correction is folded in with the first row so it is added exactly once.
        acc_sum   = acc_q + row_shift + ((tc_q && (cnt_q == '0)) ? Corr : '0);
    end

    // Next-state and datapath control for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        tc_d      = tc_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    tc_d    = tc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (last_row) begin
                    // Only the finished sum ever reaches the product register.
                    product_d = acc_sum;
                    cnt_d     = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    tc_d    = tc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides any start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            tc_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tc_q      <= tc_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q != StCalc);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_bw.sv
// Directed and randomised checks for seq_mult_bw at WIDTH=8, 2 and 16.
module tb_seq_mult_bw;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tc;
    logic [15:0] opa;
    logic [15:0] opb;
    int          wsel;

    logic        st8, st2, st16;
    logic        ready8, done8;
    logic [15:0] prod8;
    logic        ready2, done2;
    logic [3:0]  prod2;
    logic        ready16, done16;
    logic [31:0] prod16;

    logic        xready, xdone;
    logic [31:0] xprod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign st8  = start && (wsel == 8);
    assign st2  = start && (wsel == 2);
    assign st16 = start && (wsel == 16);

    seq_mult_bw #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .tc(tc), .a(opa[7:0]), .b(opb[7:0]),
        .ready(ready8), .done(done8), .product(prod8)
    );

    seq_mult_bw #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(st2), .tc(tc), .a(opa[1:0]), .b(opb[1:0]),
        .ready(ready2), .done(done2), .product(prod2)
    );

    seq_mult_bw #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(st16), .tc(tc), .a(opa), .b(opb),
        .ready(ready16), .done(done16), .product(prod16)
    );

    // Route the selected instance's outputs to common observation signals.
    always_comb begin
        xready = ready8;
        xdone  = done8;
        xprod  = 32'(prod8);
        case (wsel)
            2: begin
                xready = ready2;
                xdone  = done2;
                xprod  = 32'(prod2);
            end
            16: begin
                xready = ready16;
                xdone  = done16;
                xprod  = prod16;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product using native arithmetic, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic t,
                                            input logic [15:0] av, input logic [15:0] bv);
        longint x, y;
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        x = longint'(64'(av) & m);
        y = longint'(64'(bv) & m);
        if (t && (((x >> (w - 1)) & 1) != 0)) x = x - longint'(64'd1 << w);
        if (t && (((y >> (w - 1)) & 1) != 0)) y = y - longint'(64'd1 << w);
        return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 9))
            0: return 16'd0;
            1: return 16'd1;
            2: return m >> 1;
            3: return (m >> 1) + 16'd1;
            4: return m;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    // One complete operation on the selected instance, checking latency and the done pulse.
    task automatic run_op(input logic t, input logic [15:0] av, input logic [15:0] bv,
                          input logic [63:0] exp, input string name);
        int lat;
        lat = -1;
        @(negedge clk);
        chk({name, "_ready"}, 64'(xready), 64'd1);
        tc = t; opa = av; opb = bv; start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        opa = ~av; opb = ~bv; tc = ~t;
        for (int e = 1; e <= 3 * wsel + 4; e++) begin
            @(posedge clk);
            #1;
            if (xdone) begin
                lat = e;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(wsel));
        chk({name, "_product"}, 64'(xprod), exp);
        @(posedge clk);
        #1;
        chk({name, "_done_pulse"}, 64'(xdone), 64'd0);
        chk({name, "_held"}, 64'(xprod), exp);
    endtask

    typedef struct {
        logic        t;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[16];
        int   n, de[2];
        logic [31:0] dp[2];
        int   ndone, dedge;

        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[3]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[4]  = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
        vecs[5]  = '{1'b1, 8'h80, 8'hFF, 16'h0080};
        vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
        vecs[7]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
        vecs[8]  = '{1'b1, 8'hFF, 8'h00, 16'h0000};
        vecs[9]  = '{1'b0, 8'h01, 8'h01, 16'h0001};
        vecs[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[11] = '{1'b0, 8'h0D, 8'h0B, 16'h008F};
        vecs[12] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[13] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[14] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[15] = '{1'b1, 8'h81, 8'h7F, 16'hC0FF};

        wsel = 8; reset = 1'b1; start = 1'b0; tc = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 64'(ready8), 64'd1);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_product", 64'(prod8), 64'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].t, 16'(vecs[i].a), 16'(vecs[i].b), 64'(vecs[i].exp),
                   $sformatf("vec%0d", i));
        end

        // Start pulses during CALC with other operands must be ignored.
        @(negedge clk);
        tc = 1'b0; opa = 16'hFF; opb = 16'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0; dedge = -1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            start = (e == 3 || e == 5);
            if (start) begin
                tc = 1'b1; opa = 16'h12; opb = 16'h34;
            end
            @(posedge clk);
            #1;
            if (xdone) begin
                ndone++;
                dedge = e;
            end
        end
        chk("ignore_done_count", 64'(ndone), 64'd1);
        chk("ignore_done_edge", 64'(dedge), 64'd8);
        chk("ignore_product", 64'(xprod), 64'hFE01);

        // Start held high: back-to-back operations every WIDTH+1 cycles.
        @(negedge clk);
        tc = 1'b1; opa = 16'h7F; opb = 16'h80; start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        tc = 1'b0; opa = 16'h80; opb = 16'hFF;
        n = 0; de[0] = -1; de[1] = -1; dp[0] = '0; dp[1] = '0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (e == 4) chk("b2b_ready_calc", 64'(xready), 64'd0);
            if (xdone) begin
                de[n] = e;
                dp[n] = xprod;
                chk($sformatf("b2b_ready_done%0d", n), 64'(xready), 64'd1);
                n++;
            end
            if (n == 2) break;
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_count", 64'(n), 64'd2);
        chk("b2b_edge0", 64'(de[0]), 64'd8);
        chk("b2b_edge1", 64'(de[1]), 64'd17);
        chk("b2b_prod0", 64'(dp[0]), 64'hC080);
        chk("b2b_prod1", 64'(dp[1]), 64'h7F80);
        chk("b2b_idle_done", 64'(xdone), 64'd0);
        chk("b2b_idle_ready", 64'(xready), 64'd1);

        // Reset at edge 4 of CALC aborts the operation.
        @(negedge clk);
        tc = 1'b0; opa = 16'hFF; opb = 16'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", 64'(xready), 64'd1);
        chk("abort_done", 64'(xdone), 64'd0);
        chk("abort_product", 64'(xprod), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (xdone) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(1'b1, 16'h80, 16'h80, 64'h4000, "after_abort");

        // Start coincident with reset is discarded.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; tc = 1'b0; opa = 16'hFF; opb = 16'hFF;
        @(posedge clk);
        #1;
        chk("rst_start_ready", 64'(xready), 64'd1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (xdone) ndone++;
        end
        chk("rst_start_no_done", 64'(ndone), 64'd0);
        chk("rst_start_product", 64'(xprod), 64'd0);

        // Randomised sweeps with corner operands at each instance width.
        for (int s = 0; s < 3; s++) begin
            int cnt;
            wsel = (s == 0) ? 8 : ((s == 1) ? 2 : 16);
            cnt  = (s == 0) ? 1500 : ((s == 1) ? 300 : 800);
            for (int k = 0; k < cnt; k++) begin
                logic        t;
                logic [15:0] av, bv;
                t  = 1'($urandom_range(0, 1));
                av = pick(wsel);
                bv = pick(wsel);
                run_op(t, av, bv, ref_mul(wsel, t, av, bv),
                       $sformatf("rnd_w%0d_t%0d_%0h_%0h", wsel, t, av, bv));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
